weight_buffer_loader: RTL and testbench
=======================================

Name: weight_buffer_loader

Overview:
- Write-side counterpart of the neuron's weight/input memory.
- Accepts a streamed word sequence over a valid/ready handshake and writes it into an internal buffer at incrementing addresses.
- Publishes completion, then serves the neuron-side read port: `r_en`/`r_addr` in, registered `weight_out` one cycle later.
- One instance per vector (weights or x values); replaces the fixed init-file ROM so vectors can be reloaded at run time.

Parameters:
- DATA_SIZE, 32, width of each stored word.
- DEPTH, 16, buffer capacity in words.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle request to begin a load; sampled in IDLE and DONE only.
- cfg_count  input  ADDR_W+1  number of words to load; sampled with load_start.
- s_valid  input  1  stream word valid.
- s_data  input  DATA_SIZE  stream word.
- s_last  input  1  marks final stream word.
- s_ready  output  1  buffer accepts a word this cycle.
- busy  output  1  high in LOAD.
- load_done  output  1  level; buffer holds a complete vector.
- err_cfg  output  1  one-cycle pulse; load_start rejected.
- err_len  output  1  sticky; s_last mismatch during the last load.
- word_count  output  ADDR_W+1  latched cfg_count of the current/last load.
- r_en  input  1  read enable from the neuron.
- r_addr  input  ADDR_W  read address.
- weight_out  output  DATA_SIZE  registered read data.

Behaviour:
- Reset (`rst`=0, asynchronous): state=IDLE, write pointer=0.
- Reset values: s_ready=0, busy=0, load_done=0, err_cfg=0, err_len=0, word_count=0, weight_out=0.
- Buffer contents are not reset; reads are gated by load_done, so they are never observed.
- Reset asserted mid-LOAD aborts the load; load_done stays 0 after release.
- FSM states: IDLE, LOAD, DONE.
- IDLE / DONE, on load_start:
  - cfg_count in 1..DEPTH: latch word_count=cfg_count, pointer=0, clear err_len, load_done=0, go to LOAD next cycle.
  - cfg_count = 0 or > DEPTH: err_cfg pulses for 1 cycle; state, load_done and word_count are unchanged.
- LOAD:
  - s_ready=1 and busy=1 for the whole state; a beat transfers when s_valid & s_ready.
  - Each beat writes s_data to mem[pointer], then pointer increments.
  - Beat with pointer==word_count-1 is final: go to DONE; load_done=1 from the next cycle.
  - If s_last=0 on the final beat, set err_len; the load still completes.
  - s_last=1 on a non-final beat: set err_len, abort to IDLE, load_done stays 0. Words already written remain but are unreadable.
  - load_start is ignored in LOAD.
- DONE: s_ready=0; load_done held until an accepted load_start or reset.
- Read port:
  - When r_en=1 and load_done=1, weight_out <= mem[r_addr] at the next edge (latency 1).
  - r_addr >= word_count returns 0.
  - When r_en=0, weight_out holds its value.
  - When load_done=0, r_en is ignored and weight_out holds.
- Read/write overlap:
  - Reads and writes never overlap, since reads require DONE.
  - A reload clears load_done on the cycle after load_start, so a read in the load_start cycle itself is still served from the old contents.
- No combinational path from s_valid to s_ready.
- Arithmetic: the pointer never exceeds DEPTH-1 because word_count <= DEPTH. No wrap.

Test Plan:
- Reset, load cfg_count=4 with words 0x11,0x22,0x33,0x44, s_last on the 4th -> load_done=1 one cycle after the 4th beat, err_len=0. Reads at addresses 0..3 return 0x11..0x44 one cycle after r_en; read at address 5 returns 0.
- Same load with s_valid toggling 1,0,1,0 -> only valid cycles write; completion after the 4th accepted beat; data identical.
- cfg_count=3 with s_last on beat 2 -> err_len=1, state returns to IDLE, load_done=0, r_en has no effect. cfg_count=3 with no s_last -> load_done=1, err_len=1.
- load_start with cfg_count=0, then with cfg_count=17 (DEPTH=16) -> err_cfg pulses once each; state, load_done and word_count unchanged.
- Full load of DEPTH=16 words, then reload with count=2 (0xAA,0xBB):
  - load_done drops for the reload.
  - Address 0 reads 0xAA.
  - Address 2 reads 0, because it is >= word_count.
- Assert rst after 2 of 4 beats -> all outputs 0 immediately; after release, a fresh count=4 load completes normally.

Source files
------------

// File: rtl/weight_buffer_loader.sv
// Run-time loadable weight/input vector buffer: streamed writes over valid/ready,
// then a registered, load_done-gated read port for the neuron.
module weight_buffer_loader #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [ADDR_W:0]      cfg_count,
    input  logic                 s_valid,
    input  logic [DATA_SIZE-1:0] s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 busy,
    output logic                 load_done,
    output logic                 err_cfg,
    output logic                 err_len,
    output logic [ADDR_W:0]      word_count,
    input  logic                 r_en,
    input  logic [ADDR_W-1:0]    r_addr,
    output logic [DATA_SIZE-1:0] weight_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    state_t                state;
    state_t                next_state;
    logic [ADDR_W-1:0]     ptr;
    logic [DATA_SIZE-1:0]  mem [DEPTH];

    logic cfg_valid;
    logic start_ok;
    logic start_bad;
    logic beat;
    logic final_beat;

    assign cfg_valid  = (cfg_count != '0) && (cfg_count <= DEPTH_CNT);
    assign start_ok   = load_start && (state != LOAD) && cfg_valid;
    assign start_bad  = load_start && (state != LOAD) && !cfg_valid;

    // s_ready depends only on state, so a beat never loops s_valid back into s_ready.
    assign beat       = (state == LOAD) && s_valid;
    assign final_beat = beat && ({1'b0, ptr} == (word_count - 1'b1));

    assign s_ready    = (state == LOAD);
    assign busy       = (state == LOAD);
    assign load_done  = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (final_beat) begin
                    next_state = DONE;
                end else if (beat && s_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A length error is any disagreement between s_last and the final-beat position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            word_count <= '0;
            err_cfg    <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            err_cfg <= start_bad;
            if (start_ok) begin
                word_count <= cfg_count;
                ptr        <= '0;
                err_len    <= 1'b0;
            end else if (beat) begin
                if (!final_beat) begin
                    ptr <= ptr + 1'b1;
                end
                if (final_beat != s_last) begin
                    err_len <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            mem[ptr] <= s_data;
        end
    end

    // Addresses beyond the loaded length read as zero rather than stale contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_out <= '0;
        end else if (r_en && load_done) begin
            if ({1'b0, r_addr} < word_count) begin
                weight_out <= mem[r_addr];
            end else begin
                weight_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Directed self-checking bench for weight_buffer_loader with hand-computed expectations.
module tb_weight_buffer_loader;

    localparam int DATA_SIZE = 32;
    localparam int DEPTH = 16;
    localparam int ADDR_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 loadStart;
    logic [ADDR_W:0]      cfgCount;
    logic                 sValid;
    logic [DATA_SIZE-1:0] sData;
    logic                 sLast;
    logic                 sReady;
    logic                 busy;
    logic                 loadDone;
    logic                 errCfg;
    logic                 errLen;
    logic [ADDR_W:0]      wordCount;
    logic                 rEn;
    logic [ADDR_W-1:0]    rAddr;
    logic [DATA_SIZE-1:0] weightOut;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] firstWords [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    weight_buffer_loader #(
        .DATA_SIZE(DATA_SIZE),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_start(loadStart),
        .cfg_count(cfgCount),
        .s_valid(sValid),
        .s_data(sData),
        .s_last(sLast),
        .s_ready(sReady),
        .busy(busy),
        .load_done(loadDone),
        .err_cfg(errCfg),
        .err_len(errLen),
        .word_count(wordCount),
        .r_en(rEn),
        .r_addr(rAddr),
        .weight_out(weightOut)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last);
        sValid = valid;
        sData  = data;
        sLast  = last;
        tick();
        sValid = 1'b0;
        sLast  = 1'b0;
    endtask

    task automatic startLoad(input logic [ADDR_W:0] count);
        loadStart = 1'b1;
        cfgCount  = count;
        tick();
        loadStart = 1'b0;
        cfgCount  = '0;
    endtask

    task automatic readWord(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] expected);
        rEn   = 1'b1;
        rAddr = addr;
        tick();
        rEn   = 1'b0;
        checkOutput(tag, weightOut, expected);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(sReady), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_load_done"}, 32'(loadDone), 32'h0);
        checkOutput({tag, "_err_cfg"}, 32'(errCfg), 32'h0);
        checkOutput({tag, "_err_len"}, 32'(errLen), 32'h0);
        checkOutput({tag, "_word_count"}, 32'(wordCount), 32'h0);
        checkOutput({tag, "_weight_out"}, weightOut, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        rst = 1'b0;
        loadStart = 1'b0;
        cfgCount = '0;
        sValid = 1'b0;
        sData = '0;
        sLast = 1'b0;
        rEn = 1'b0;
        rAddr = '0;

        // Reset state, then a plain four-word load.
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        startLoad(5'd4);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        checkOutput("t1_s_ready", 32'(sReady), 32'h1);
        checkOutput("t1_word_count", 32'(wordCount), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1_done_before_beat%0d", i), 32'(loadDone), 32'h0);
            applyStimulus(1'b1, firstWords[i], i == 3);
        end
        checkOutput("t1_load_done", 32'(loadDone), 32'h1);
        checkOutput("t1_err_len", 32'(errLen), 32'h0);
        checkOutput("t1_s_ready_done", 32'(sReady), 32'h0);
        for (int i = 0; i < 4; i++) begin
            readWord($sformatf("t1_read%0d", i), ADDR_W'(i), firstWords[i]);
        end
        rAddr = 4'd0;
        tick();
        checkOutput("t1_hold", weightOut, 32'h44);
        readWord("t1_read5", 4'd5, 32'h0);

        // Reload with valid toggling; a read in the load_start cycle sees old data.
        rEn = 1'b1;
        rAddr = 4'd1;
        startLoad(5'd4);
        rEn = 1'b0;
        checkOutput("t2_read_in_start", weightOut, 32'h22);
        checkOutput("t2_load_done_drop", 32'(loadDone), 32'h0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i % 2 == 0, (i % 2 == 0) ? firstWords[i / 2] : 32'hDEAD, i == 6);
            if (i == 5) begin
                checkOutput("t2_not_done_early", 32'(loadDone), 32'h0);
            end
        end
        checkOutput("t2_load_done", 32'(loadDone), 32'h1);
        for (int i = 0; i < 4; i++) begin
            readWord($sformatf("t2_read%0d", i), ADDR_W'(i), firstWords[i]);
        end

        // Early s_last aborts; missing s_last completes with err_len.
        startLoad(5'd3);
        checkOutput("t3_err_len_cleared", 32'(errLen), 32'h0);
        applyStimulus(1'b1, 32'hA1, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b1);
        checkOutput("t3_abort_err_len", 32'(errLen), 32'h1);
        checkOutput("t3_abort_load_done", 32'(loadDone), 32'h0);
        checkOutput("t3_abort_busy", 32'(busy), 32'h0);
        readWord("t3_read_ignored", 4'd0, 32'h44);
        startLoad(5'd3);
        applyStimulus(1'b1, 32'hB1, 1'b0);
        applyStimulus(1'b1, 32'hB2, 1'b0);
        applyStimulus(1'b1, 32'hB3, 1'b0);
        checkOutput("t3_nolast_load_done", 32'(loadDone), 32'h1);
        checkOutput("t3_nolast_err_len", 32'(errLen), 32'h1);
        readWord("t3_read2", 4'd2, 32'hB3);

        // Rejected configurations leave everything in place.
        startLoad(5'd0);
        checkOutput("t4_zero_err_cfg", 32'(errCfg), 32'h1);
        checkOutput("t4_zero_load_done", 32'(loadDone), 32'h1);
        checkOutput("t4_zero_word_count", 32'(wordCount), 32'd3);
        checkOutput("t4_zero_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("t4_zero_err_cfg_clear", 32'(errCfg), 32'h0);
        startLoad(5'd17);
        checkOutput("t4_big_err_cfg", 32'(errCfg), 32'h1);
        checkOutput("t4_big_load_done", 32'(loadDone), 32'h1);
        checkOutput("t4_big_word_count", 32'(wordCount), 32'd3);
        tick();
        checkOutput("t4_big_err_cfg_clear", 32'(errCfg), 32'h0);

        // Full-depth load followed by a short reload.
        startLoad(5'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), i == 15);
        end
        checkOutput("t5_full_load_done", 32'(loadDone), 32'h1);
        checkOutput("t5_full_err_len", 32'(errLen), 32'h0);
        readWord("t5_read15", 4'd15, 32'h10F);
        readWord("t5_read7", 4'd7, 32'h107);
        startLoad(5'd2);
        checkOutput("t5_reload_done_drop", 32'(loadDone), 32'h0);
        applyStimulus(1'b1, 32'hAA, 1'b0);
        applyStimulus(1'b1, 32'hBB, 1'b1);
        checkOutput("t5_reload_done", 32'(loadDone), 32'h1);
        readWord("t5_read0", 4'd0, 32'hAA);
        readWord("t5_read2", 4'd2, 32'h0);
        readWord("t5_read1", 4'd1, 32'hBB);

        // Asynchronous reset in the middle of a load.
        startLoad(5'd4);
        applyStimulus(1'b1, 32'h11, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("t6_async");
        tick();
        rst = 1'b1;
        tick();
        checkOutput("t6_after_release_done", 32'(loadDone), 32'h0);
        startLoad(5'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hC1 + 32'(i), i == 3);
        end
        checkOutput("t6_fresh_load_done", 32'(loadDone), 32'h1);
        checkOutput("t6_fresh_err_len", 32'(errLen), 32'h0);
        readWord("t6_read3", 4'd3, 32'hC4);
        readWord("t6_read0", 4'd0, 32'hC1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
